// File: rtl/counter_bcd_n.sv
// Multi-digit BCD up/down counter with synchronous clear/load, wrap or
// saturate at the limits, combinational terminal count and sticky overflow.
module counter_bcd_n #(
  parameter int DIGITS = 6,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  f_in,
  input  logic                  clr_n,
  input  logic                  sclr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  ena,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf
);

  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_val;
  logic [3:0]          digit;
  logic [3:0]          d_digit;
  logic                carry;
  logic                at_max;
  logic                at_min;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave one unassigned and infer a latch.
  always_comb begin
    count_next = q;
    load_val   = '0;
    carry      = 1'b1;
    at_max     = 1'b1;
    at_min     = 1'b1;
    digit      = '0;
    d_digit    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit  = q[4*k +: 4];
      at_max = at_max & (digit == 4'd9);
      at_min = at_min & (digit == 4'd0);
      // Carry/borrow ripples from digit 0 upward within one evaluation.
      if (carry) begin
        if (up_dn) begin
          if (digit >= 4'd9) begin
            count_next[4*k +: 4] = 4'd0;
          end else begin
            count_next[4*k +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[4*k +: 4] = 4'd9;
          end else begin
            count_next[4*k +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      d_digit = d[4*k +: 4];
      load_val[4*k +: 4] = (d_digit > 4'd9) ? 4'd9 : d_digit;
    end
  end

  assign tc = ena & ~sclr & ~load & (up_dn ? at_max : at_min);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge f_in or negedge clr_n) begin
    if (!clr_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (sclr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= load_val;
      ovf <= 1'b0;
    end else if (ena) begin
      // In saturate mode a terminal-count edge leaves q at the limit.
      if (WRAP || !tc) q <= count_next;
      if (tc) ovf <= 1'b1;
    end
  end

endmodule
